// File: rtl/hnf_rxchan_lcrd.sv
// CHI RX link-layer receiver for one HN-F inbound channel: L-credit counter, STOP/RUN/DRAIN FSM, flit FIFO.
// Optional TgtID filtering is enabled by defining HNF_RXCHAN_TGTID_CHK_EN.
module hnf_rxchan_lcrd #(
    parameter int          FLIT_W    = 132,
    parameter int          DEPTH     = 8,
    parameter int          MAX_LCRD  = 4,
    parameter int          TGTID_LSB = 4,
    parameter logic [6:0]  HN_ID     = 7'h0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         link_en,
    output logic                         link_active,
    input  logic [FLIT_W-1:0]            RXFLIT,
    input  logic                         RXFLITV,
    input  logic                         RXFLITPEND,
    output logic                         RXLCRDV,
    output logic [FLIT_W-1:0]            deq_data,
    output logic                         deq_valid,
    input  logic                         deq_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         err_nocredit,
    output logic                         err_tgtid,
    output logic [1:0]                   link_state
);

    localparam int CW = $clog2(MAX_LCRD + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(DEPTH + MAX_LCRD + 2);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e            state, state_next;
    logic [CW-1:0]     lcrd_out, lcrd_out_next;
    logic              lcrdv_q, lcrdv_next;
    logic [OW-1:0]     occ_next;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [FLIT_W-1:0] mem [DEPTH];
    logic              consume, nocredit, tgt_ok, push, pop;
    logic [SW-1:0]     out_eff, fill;

    // Handshake: the head flit leaves the FIFO on a cycle where deq_valid and deq_ready are both 1.
    assign consume  = RXFLITV && (lcrd_out != '0);
    assign nocredit = RXFLITV && (lcrd_out == '0);
    assign push     = consume && tgt_ok;
    assign pop      = deq_valid && deq_ready;

`ifdef HNF_RXCHAN_TGTID_CHK_EN
    logic err_tgtid_q;
    logic unused_inputs;
    assign tgt_ok        = (RXFLIT[TGTID_LSB +: 7] == HN_ID);
    assign err_tgtid     = err_tgtid_q;
    assign unused_inputs = RXFLITPEND;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) err_tgtid_q <= 1'b0;
        else       err_tgtid_q <= consume && !tgt_ok;
    end
`else
    logic unused_inputs;
    assign tgt_ok        = 1'b1;
    assign err_tgtid     = 1'b0;
    assign unused_inputs = RXFLITPEND ^ (^(RXFLIT[TGTID_LSB +: 7] ^ HN_ID));
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_STOP:  if (link_en) state_next = ST_RUN;
            ST_RUN:   if (!link_en) state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (link_en)                 state_next = ST_RUN;
                else if (lcrd_out == '0)     state_next = ST_STOP;
            end
            default:  state_next = ST_STOP;
        endcase
    end

    // A grant already registered but not yet counted is included, so neither limit can be overshot.
    assign out_eff = SW'(lcrd_out) + SW'(lcrdv_q);
    assign fill    = SW'(occupancy) + out_eff;

    always_comb begin
        lcrdv_next    = (state == ST_RUN) && (state_next == ST_RUN) &&
                        (out_eff < SW'(MAX_LCRD)) && (fill < SW'(DEPTH));
        lcrd_out_next = lcrd_out + CW'(lcrdv_q) - CW'(consume);
        occ_next      = occupancy + OW'(push) - OW'(pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_STOP;
            lcrd_out     <= '0;
            lcrdv_q      <= 1'b0;
            occupancy    <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            err_nocredit <= 1'b0;
        end else begin
            state        <= state_next;
            lcrd_out     <= lcrd_out_next;
            lcrdv_q      <= lcrdv_next;
            occupancy    <= occ_next;
            err_nocredit <= nocredit;
            if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
        end
    end

    // Storage carries no reset; validity is tracked solely by occupancy.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= RXFLIT;
    end

    assign deq_data    = mem[rd_ptr];
    assign deq_valid   = (occupancy != '0);
    assign RXLCRDV     = lcrdv_q;
    assign link_active = (state != ST_STOP);
    assign link_state  = state;

endmodule

// File: tb/tb_hnf_rxchan_lcrd.sv
// Scoreboard bench for hnf_rxchan_lcrd: credit grants, FIFO order, drain sequencing and error pulses.
module tb_hnf_rxchan_lcrd;

    localparam int         FLIT_W   = 132;
    localparam int         DEPTH    = 8;
    localparam int         MAX_LCRD = 4;
    localparam logic [6:0] HN       = 7'h05;
`ifdef HNF_RXCHAN_TGTID_CHK_EN
    localparam bit TGT_CHK = 1'b1;
`else
    localparam bit TGT_CHK = 1'b0;
`endif

    logic              clk, rst, link_en, link_active;
    logic [FLIT_W-1:0] RXFLIT;
    logic              RXFLITV, RXFLITPEND, RXLCRDV;
    logic [FLIT_W-1:0] deq_data;
    logic              deq_valid, deq_ready;
    logic [3:0]        occupancy;
    logic              err_nocredit, err_tgtid;
    logic [1:0]        link_state;

    hnf_rxchan_lcrd #(
        .FLIT_W(FLIT_W), .DEPTH(DEPTH), .MAX_LCRD(MAX_LCRD), .TGTID_LSB(4), .HN_ID(HN)
    ) dut (
        .clock(clk), .reset(rst), .link_en(link_en), .link_active(link_active),
        .RXFLIT(RXFLIT), .RXFLITV(RXFLITV), .RXFLITPEND(RXFLITPEND), .RXLCRDV(RXLCRDV),
        .deq_data(deq_data), .deq_valid(deq_valid), .deq_ready(deq_ready),
        .occupancy(occupancy), .err_nocredit(err_nocredit), .err_tgtid(err_tgtid),
        .link_state(link_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks, errors, mon_checks, mon_errors, grant_cnt, sent_cnt, seq;
    logic [FLIT_W-1:0] exp_q[$];

    function automatic logic [FLIT_W-1:0] make_flit(input logic [31:0] p, input logic [6:0] tgt);
        logic [FLIT_W-1:0] f;
        f = '0;
        f[131:100] = p;
        f[63:32]   = ~p;
        f[10:4]    = tgt;
        return f;
    endfunction

    function automatic int credits();
        return grant_cnt - sent_cnt;
    endfunction

    task automatic check(input string name, input logic [FLIT_W-1:0] act, input logic [FLIT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] tgt, input bit expect_push);
        RXFLIT  = make_flit(32'(seq), tgt);
        RXFLITV = 1'b1;
        seq++;
        sent_cnt++;
        if (expect_push) exp_q.push_back(RXFLIT);
    endtask

    task automatic drain_all(input string name);
        deq_ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check({name, "_timeout"}, 132'(exp_q.size()), 0);
        tick();
        @(negedge clk);
        check({name, "_occ"}, occupancy, 0);
        check({name, "_valid"}, deq_valid, 0);
        deq_ready = 1'b0;
    endtask

    // Grant counter and pop monitor, both sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst && RXLCRDV) grant_cnt++;
    end

    always @(negedge clk) begin
        logic [FLIT_W-1:0] e;
        if (!rst && deq_valid && deq_ready) begin
            mon_checks++;
            if (exp_q.size() == 0) begin
                mon_errors++;
                $display("FAIL deq_unexpected actual=%0h required=none", deq_data);
            end else begin
                e = exp_q.pop_front();
                if (deq_data !== e) begin
                    mon_errors++;
                    $display("FAIL deq_data actual=%0h required=%0h", deq_data, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, g0;
        logic [7:0] v;
        rst = 1'b1; link_en = 1'b0; RXFLIT = '0; RXFLITV = 1'b0; RXFLITPEND = 1'b0; deq_ready = 1'b0;
        checks = 0; errors = 0; mon_checks = 0; mon_errors = 0; grant_cnt = 0; sent_cnt = 0; seq = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_lcrdv", RXLCRDV, 0);
        check("rst_valid", deq_valid, 0);
        check("rst_active", link_active, 0);
        check("rst_occ", occupancy, 0);
        check("rst_errnc", err_nocredit, 0);
        check("rst_errtg", err_tgtid, 0);
        check("rst_state", link_state, 0);
        @(posedge clk); #1; rst = 1'b0;

        // Flit with no credit while stopped
        tick(); RXFLIT = make_flit(32'h99, HN); RXFLITV = 1'b1;
        tick(); RXFLITV = 1'b0;
        @(negedge clk);
        check("nocred_stop_err", err_nocredit, 1);
        check("nocred_stop_occ", occupancy, 0);
        check("nocred_stop_valid", deq_valid, 0);
        tick(); @(negedge clk);
        check("nocred_stop_pulse", err_nocredit, 0);

        // Link up: four back-to-back grants
        tick(); link_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            v[i] = RXLCRDV;
        end
        check("grant_pattern", v, 8'b0011_1100);
        check("grant_count", grant_cnt, 4);
        check("run_state", link_state, 1);
        check("run_active", link_active, 1);

        // Fill the FIFO with credit-driven sends
        n = 0;
        for (int c = 0; c < 200 && n < 8; c++) begin
            tick();
            if (credits() > 0) begin send(HN, 1'b1); n++; end
            else RXFLITV = 1'b0;
        end
        tick(); RXFLITV = 1'b0;
        check("fill_sent", n, 8);
        g0 = grant_cnt;
        repeat (6) tick();
        @(negedge clk);
        check("full_occ", occupancy, 8);
        check("full_no_grant", grant_cnt - g0, 0);
        check("full_credits", credits(), 0);

        // No credit while full
        tick(); RXFLIT = make_flit(32'h77, HN); RXFLITV = 1'b1;
        tick(); RXFLITV = 1'b0;
        @(negedge clk);
        check("nocred_full_err", err_nocredit, 1);
        check("nocred_full_occ", occupancy, 8);

        // One pop frees a slot, re-credited two cycles later
        tick(); deq_ready = 1'b1;
        @(negedge clk); v[0] = RXLCRDV;
        tick(); deq_ready = 1'b0;
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            v[i] = RXLCRDV;
        end
        check("pop_grant_pattern", v[5:0], 6'b000100);
        check("pop_occ", occupancy, 7);

        // Down to three, then simultaneous push and pop
        tick(); deq_ready = 1'b1;
        repeat (3) tick();
        tick(); deq_ready = 1'b0;
        @(negedge clk);
        check("occ3", occupancy, 3);
        for (int c = 0; c < 20 && credits() == 0; c++) tick();
        tick(); send(HN, 1'b1); deq_ready = 1'b1;
        tick(); RXFLITV = 1'b0; deq_ready = 1'b0;
        @(negedge clk);
        check("push_pop_occ", occupancy, 3);

        // Stream of 20 flits through the wrapping FIFO
        deq_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 400 && n < 20; c++) begin
            tick();
            if (credits() > 0) begin send(HN, 1'b1); n++; end
            else RXFLITV = 1'b0;
        end
        tick(); RXFLITV = 1'b0;
        check("stream_sent", n, 20);
        drain_all("stream");
        repeat (8) tick();
        check("credits_refill", credits(), 4);

        // Deactivate with three credits outstanding
        g0 = grant_cnt;
        tick(); send(HN, 1'b1);
        tick(); RXFLITV = 1'b0; link_en = 1'b0;
        tick(); @(negedge clk);
        check("drain_state", link_state, 2);
        check("drain_active", link_active, 1);
        check("drain_credits", credits(), 3);
        tick(); send(HN, 1'b1);
        tick(); send(HN, 1'b1);
        tick(); send(HN, 1'b1);
        tick(); RXFLITV = 1'b0;
        @(negedge clk);
        check("drain_last_state", link_state, 2);
        check("drain_last_active", link_active, 1);
        tick(); @(negedge clk);
        check("stop_state", link_state, 0);
        check("stop_active", link_active, 0);
        check("drain_no_grant", grant_cnt - g0, 0);
        check("drain_occ", occupancy, 4);
        drain_all("drain");

        // TgtID mismatch flit
        link_en = 1'b1;
        for (int c = 0; c < 100 && credits() < 4; c++) tick();
        check("relink_credits", credits(), 4);
        tick(); send(7'h06, !TGT_CHK);
        tick(); RXFLITV = 1'b0;
        @(negedge clk);
        check("tgt_err", err_tgtid, 132'(TGT_CHK));
        check("tgt_occ", occupancy, TGT_CHK ? 0 : 1);
        repeat (6) tick();
        check("tgt_regrant", credits(), 4);
        drain_all("tgt");

        $display("CHECKS %0d ERRORS %0d", checks + mon_checks, errors + mon_errors);
        $finish;
    end

endmodule
